// File: rtl/jpeg_pkg.sv
// Shared types for the JPEG memory arbiter: bus widths,
// arbiter state encoding and the posted-write command record.
package jpeg_pkg;

    localparam int ADDR_W = 31;
    localparam int DATA_W = 16;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } wr_cmd_t;

endpackage

// File: rtl/jpeg_mem_arbiter_if.sv
// Bundle of the read-requester, write-requester and memory-master
// Avalon-MM signals seen by the arbiter (slave) and its environment (master).
interface jpeg_mem_arbiter_if;
    import jpeg_pkg::*;

    logic [ADDR_W-1:0] r_address;
    logic              r_read;
    logic [BE_W-1:0]   r_byteenable;
    logic [DATA_W-1:0] r_readdata;
    logic              r_waitrequest;

    logic [ADDR_W-1:0] w_address;
    logic              w_write;
    logic [DATA_W-1:0] w_writedata;
    logic [BE_W-1:0]   w_byteenable;
    logic              w_waitrequest;

    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [BE_W-1:0]   m_byteenable;
    logic [DATA_W-1:0] m_readdata;
    logic              m_waitrequest;

    modport slave (
        input  r_address, r_read, r_byteenable,
        output r_readdata, r_waitrequest,
        input  w_address, w_write, w_writedata, w_byteenable,
        output w_waitrequest,
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_readdata, m_waitrequest
    );

    modport master (
        output r_address, r_read, r_byteenable,
        input  r_readdata, r_waitrequest,
        output w_address, w_write, w_writedata, w_byteenable,
        input  w_waitrequest,
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_readdata, m_waitrequest
    );

endinterface

// File: rtl/jpeg_wr_fifo.sv
// Posted-write FIFO with per-entry valid bits and an address
// comparator per entry used for read-after-write hazard detection.
module jpeg_wr_fifo
    import jpeg_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  wr_cmd_t           push_cmd_i,
    input  logic              pop_i,
    output wr_cmd_t           head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o,
    input  logic [ADDR_W-1:0] cmp_addr_i,
    output logic [DEPTH-1:0]  hit_o
);

    wr_cmd_t          mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] wptr_d;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] rptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Push and pop never target the same slot: push needs !full, pop needs !empty.
    always_comb begin
        vld_d  = vld_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_pop) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + 1'b1;
        end
        if (do_push) begin
            vld_d[wptr_q] = 1'b1;
            wptr_d        = wptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        hit_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_o[i] = vld_q[i] && (mem_q[i].addr == cmp_addr_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_cmd_i;
        end
    end

endmodule

// File: rtl/jpeg_mem_arbiter.sv
// Arbitrates a read requester and a posted-write requester onto one
// Avalon-MM master, with write starvation guard and RAW hazard ordering.
module jpeg_mem_arbiter
    import jpeg_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    jpeg_mem_arbiter_if.slave   bus,
    output logic                idle
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    arb_state_e            state_q;
    arb_state_e            state_d;
    wr_cmd_t               cmd_q;
    wr_cmd_t               cmd_d;
    logic [SW-1:0]         starve_q;
    logic [SW-1:0]         starve_d;

    wr_cmd_t               push_cmd;
    wr_cmd_t               head;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic [FIFO_DEPTH-1:0] hit;
    logic                  push;
    logic                  pop;
    logic                  go_wr;
    logic                  starved;

    logic                  m_read;
    logic                  m_write;
    logic [BE_W-1:0]       m_be;
    logic                  r_wait;

    assign push     = bus.w_write && !full;
    assign push_cmd = '{addr: bus.w_address,
                        data: bus.w_writedata,
                        be:   bus.w_byteenable};

    jpeg_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_cmd_i (push_cmd),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .cmp_addr_i (bus.r_address),
        .hit_o      (hit)
    );

    assign starved = (starve_q == SW'(STARVE_LIMIT));

    // Writes go first unless a read is waiting and nothing forces them ahead.
    assign go_wr = !empty && (!bus.r_read
                              || (count >= CNT_W'(FIFO_DEPTH - 1))
                              || starved
                              || (|hit));

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        m_read  = 1'b0;
        m_write = 1'b0;
        m_be    = '0;
        r_wait  = 1'b1;
        pop     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (go_wr) begin
                    state_d = ARB_WR;
                    cmd_d   = head;
                end else if (bus.r_read) begin
                    state_d = ARB_RD;
                    cmd_d   = '{addr: bus.r_address,
                                data: '0,
                                be:   bus.r_byteenable};
                end
            end
            ARB_RD: begin
                m_read = 1'b1;
                m_be   = cmd_q.be;
                if (!bus.m_waitrequest) begin
                    r_wait  = 1'b0;
                    state_d = ARB_IDLE;
                end
            end
            ARB_WR: begin
                m_write = 1'b1;
                m_be    = cmd_q.be;
                if (!bus.m_waitrequest) begin
                    pop     = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (pop) begin
            starve_d = '0;
        end else if (!empty && (state_q != ARB_WR) && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            cmd_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            starve_q <= starve_d;
        end
    end

    assign bus.m_read        = m_read;
    assign bus.m_write       = m_write;
    assign bus.m_byteenable  = m_be;
    assign bus.m_address     = cmd_q.addr;
    assign bus.m_writedata   = cmd_q.data;
    assign bus.r_waitrequest = r_wait;
    assign bus.r_readdata    = bus.m_readdata;
    assign bus.w_waitrequest = full;

    assign idle = (count == '0) && (state_q == ARB_IDLE) && !bus.w_write;

endmodule

// File: tb/tb_jpeg_mem_arbiter.sv
// Scoreboard bench: program-order memory model predicts reads and
// master writes; a negedge monitor compares what the DUT presents.
`timescale 1ns/1ps
module tb_jpeg_mem_arbiter;
    import jpeg_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic idle;

    jpeg_mem_arbiter_if bus();

    jpeg_mem_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .idle  (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [30:0]   a;
        logic [15:0] d;
        logic [1:0]  be;
    } wexp_t;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int mode = 0;
    int both_hi = 0;
    int act_cnt = 0;
    int last_push_cyc = -1;

    logic [15:0] ref_mem [bit [30:0]];
    logic [15:0] slv_mem [bit [30:0]];
    wexp_t       wq [$];
    logic [15:0] rq [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] merge(input logic [15:0] o,
                                          input logic [15:0] n,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = o;
        if (be[0]) r[7:0] = n[7:0];
        if (be[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    function automatic logic [15:0] rd_model(input bit [30:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory slave: response for the current cycle is set after outputs settle.
    initial begin
        logic w;
        bus.m_waitrequest = 1'b1;
        bus.m_readdata = '0;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0: w = 1'b0;
                1: w = 1'b1;
                default: w = ($urandom_range(0, 9) < 3);
            endcase
            bus.m_waitrequest = w;
            bus.m_readdata = slv_mem.exists(bus.m_address)
                           ? slv_mem[bus.m_address] : 16'h0;
        end
    end

    // Monitor: master-side writes and requester-side read completions.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.m_read && bus.m_write) both_hi++;
            if (bus.m_read || bus.m_write) act_cnt++;
            if (bus.m_write && !bus.m_waitrequest) begin
                logic [15:0] o;
                wexp_t e;
                o = slv_mem.exists(bus.m_address)
                  ? slv_mem[bus.m_address] : 16'h0;
                slv_mem[bus.m_address] =
                    merge(o, bus.m_writedata, bus.m_byteenable);
                if (wq.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_mwrite: got addr %h, expected none",
                             bus.m_address);
                end else begin
                    e = wq.pop_front();
                    chk("mwrite_addr", 32'(bus.m_address), 32'(e.a));
                    chk("mwrite_data", 32'(bus.m_writedata), 32'(e.d));
                    chk("mwrite_be", 32'(bus.m_byteenable), 32'(e.be));
                end
            end
            if (bus.r_read && !bus.r_waitrequest) begin
                if (rq.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_rdone: got data %h, expected none",
                             bus.r_readdata);
                end else begin
                    chk("rd_data", 32'(bus.r_readdata), 32'(rq.pop_front()));
                end
            end
        end
    end

    task automatic do_write(input bit [30:0] a, input logic [15:0] d,
                            input logic [1:0] be);
        int n = 0;
        bus.w_address = a;
        bus.w_writedata = d;
        bus.w_byteenable = be;
        bus.w_write = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (bus.w_waitrequest && n < BUDGET);
        if (bus.w_waitrequest) begin
            checks++;
            errs++;
            $display("FAIL wr_timeout: got waitrequest after %0d cycles, expected accept", n);
        end else begin
            wexp_t e;
            e.a = a;
            e.d = d;
            e.be = be;
            wq.push_back(e);
            ref_mem[a] = merge(rd_model(a), d, be);
            last_push_cyc = cyc;
        end
        @(posedge clk);
        #1;
        bus.w_write = 1'b0;
    endtask

    task automatic do_read(input bit [30:0] a, input bit keep);
        int n = 0;
        rq.push_back(rd_model(a));
        bus.r_address = a;
        bus.r_byteenable = 2'b11;
        bus.r_read = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (bus.r_waitrequest && n < BUDGET);
        if (bus.r_waitrequest) begin
            checks++;
            errs++;
            $display("FAIL rd_timeout: got waitrequest after %0d cycles, expected completion", n);
        end
        @(posedge clk);
        #1;
        if (!keep) bus.r_read = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(idle && wq.size() == 0) && n < 400);
        chk(name, 32'(idle), 32'd1);
        chk({name, "_wq"}, 32'(wq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.r_address = '0;
        bus.r_read = 1'b0;
        bus.r_byteenable = '0;
        bus.w_address = '0;
        bus.w_write = 1'b0;
        bus.w_writedata = '0;
        bus.w_byteenable = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mread", 32'(bus.m_read), 32'd0);
        chk("rst_mwrite", 32'(bus.m_write), 32'd0);
        chk("rst_mbe", 32'(bus.m_byteenable), 32'd0);
        chk("rst_rwait", 32'(bus.r_waitrequest), 32'd1);
        chk("rst_wwait", 32'(bus.w_waitrequest), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read with an immediately ready memory.
        slv_mem[31'h100] = 16'hBEEF;
        ref_mem[31'h100] = 16'hBEEF;
        mode = 0;
        rq.push_back(16'hBEEF);
        bus.r_address = 31'h100;
        bus.r_byteenable = 2'b11;
        bus.r_read = 1'b1;
        @(negedge clk);
        chk("rd_c0_mread", 32'(bus.m_read), 32'd0);
        chk("rd_c0_rwait", 32'(bus.r_waitrequest), 32'd1);
        @(negedge clk);
        chk("rd_c1_mread", 32'(bus.m_read), 32'd1);
        chk("rd_c1_addr", 32'(bus.m_address), 32'h100);
        chk("rd_c1_rwait", 32'(bus.r_waitrequest), 32'd0);
        chk("rd_c1_rdata", 32'(bus.r_readdata), 32'hBEEF);
        @(posedge clk);
        #1;
        bus.r_read = 1'b0;
        @(negedge clk);
        chk("rd_c2_mread", 32'(bus.m_read), 32'd0);
        chk("rd_c2_idle", 32'(idle), 32'd1);
        @(posedge clk);
        #1;

        // Posting: four writes fill the FIFO while memory stalls.
        mode = 1;
        for (int i = 0; i < 4; i++) begin
            do_write(31'h10 + 31'(i), 16'hA000 + 16'(i), 2'b11);
        end
        bus.w_address = 31'h14;
        bus.w_writedata = 16'hA004;
        bus.w_byteenable = 2'b11;
        bus.w_write = 1'b1;
        @(negedge clk);
        chk("post_full_wwait", 32'(bus.w_waitrequest), 32'd1);
        chk("post_full_idle", 32'(idle), 32'd0);
        @(posedge clk);
        #1;
        bus.w_write = 1'b0;
        mode = 0;
        wait_idle("post_drain_idle");

        // Starvation: continuous reads, one write must still get out.
        slv_mem[31'h200] = 16'h5A5A;
        ref_mem[31'h200] = 16'h5A5A;
        last_push_cyc = -1;
        fork
            begin
                for (int i = 0; i < 14; i++) do_read(31'h200, i != 13);
            end
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                do_write(31'h300, 16'hC0DE, 2'b11);
            end
            begin
                int n = 0;
                int lat;
                while (last_push_cyc < 0 && n < 60) begin
                    @(negedge clk);
                    n++;
                end
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.m_write && n < 60);
                lat = cyc - (last_push_cyc + 1);
                checks++;
                if (!bus.m_write || lat > 10) begin
                    errs++;
                    $display("FAIL starve_latency: got %0d cycles, required <= 10", lat);
                end
            end
        join
        wait_idle("starve_idle");

        // RAW hazard: read of a just-posted address must see the new data.
        slv_mem[31'h40] = 16'h0BAD;
        ref_mem[31'h40] = 16'h0BAD;
        do_write(31'h40, 16'h1234, 2'b11);
        fork
            do_read(31'h40, 1'b0);
            begin
                bit wr_seen = 1'b0;
                int n = 0;
                while (n < 60) begin
                    @(negedge clk);
                    n++;
                    if (bus.m_write && !bus.m_waitrequest
                        && bus.m_address == 31'h40) wr_seen = 1'b1;
                    if (bus.m_read) break;
                end
                chk("raw_write_first", 32'(wr_seen), 32'd1);
            end
        join
        wait_idle("raw_idle");

        // Reset while a write is stalled on the master.
        mode = 1;
        do_write(31'h500, 16'h7777, 2'b11);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.m_write && n < 20);
            chk("rstop_in_wr", 32'(bus.m_write), 32'd1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstop_mwrite", 32'(bus.m_write), 32'd0);
        chk("rstop_idle", 32'(idle), 32'd1);
        chk("rstop_wwait", 32'(bus.w_waitrequest), 32'd0);
        chk("rstop_mbe", 32'(bus.m_byteenable), 32'd0);
        wq.delete();
        ref_mem.delete(31'h500);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode = 0;
        begin
            int a0;
            a0 = act_cnt;
            repeat (10) @(negedge clk);
            chk("rstop_quiet", 32'(act_cnt - a0), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random mix of reads and posted writes on a small address set.
        mode = 2;
        for (int i = 0; i < 300; i++) begin
            bit [30:0] a;
            a = 31'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                do_write(a, 16'($urandom), 2'($urandom_range(1, 3)));
            else
                do_read(a, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        mode = 0;
        wait_idle("rand_idle");
        chk("rand_rq_empty", 32'(rq.size()), 32'd0);
        chk("never_rd_and_wr", 32'(both_hi), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/jpeg_mem_arbiter.md
JPEG_MEM_ARBITER -- requirements
Module: jpeg_mem_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of posted-write FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning the cycles a pending write may wait before it is forced ahead of reads.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have read-requester ports: r_address in 31 (word address); r_read in 1; r_byteenable in 2; r_readdata out 16; r_waitrequest out 1.
REQ-006 SHALL have write-requester ports: w_address in 31; w_write in 1; w_writedata in 16; w_byteenable in 2; w_waitrequest out 1.
REQ-007 SHALL have master ports: m_address out 31; m_read out 1; m_write out 1; m_writedata out 16; m_byteenable out 2; m_readdata in 16; m_waitrequest in 1.
REQ-008 SHALL have port idle, output, 1 bit: high when no write is pending and no transfer is in flight.

Function
REQ-009 SHALL implement Avalon-MM semantics on all three ports: a command completes in the cycle its waitrequest is low; readdata is valid in that same cycle.
REQ-010 SHALL post writes into a FIFO: w_waitrequest = (count == FIFO_DEPTH), combinationally; a push occurs when w_write && !w_waitrequest and stores {address, data, byteenable}.
REQ-011 SHALL keep count unchanged on a simultaneous push and pop, and SHALL accept a push on the cycle the FIFO leaves full only from the next cycle (w_waitrequest is computed from the registered count).
REQ-012 SHALL run a state machine IDLE/RD/WR, with m_* driven only from registered state and captured command registers.
REQ-013 In IDLE, SHALL go to WR if the FIFO is non-empty and any of these holds: !r_read; count >= FIFO_DEPTH-1; starve == STARVE_LIMIT; or r_address equals the address of any valid FIFO entry (RAW hazard).
REQ-014 In IDLE, SHALL otherwise go to RD if r_read is high, else stay in IDLE; on entry to RD or WR, SHALL capture the command (r_* or the FIFO head).
REQ-015 In RD, SHALL assert m_read with the captured address and byteenable; on !m_waitrequest, SHALL drop r_waitrequest for exactly that cycle, pass r_readdata = m_readdata, and return to IDLE.
REQ-016 In WR, SHALL assert m_write with the FIFO head; on !m_waitrequest, SHALL pop and return to IDLE.
REQ-017 SHALL hold r_waitrequest high in every other cycle, including all cycles where r_read is low.
REQ-018 SHALL give one idle bubble cycle between transfers, so minimum transfer latency is 2 cycles from request to completion.
REQ-019 starve counter: SHALL increment each cycle the FIFO is non-empty and state != WR, saturate at STARVE_LIMIT, and clear on WR completion.
REQ-020 SHALL drive idle = (count == 0) && (state == IDLE) && !w_write.
REQ-021 SHALL drive m_read/m_write to 0 and m_byteenable to 0 outside RD/WR; m_address and m_writedata are don't-care there.
REQ-022 SHALL never assert m_read and m_write together.

Reset
REQ-023 On rst_n low at a clock edge, SHALL set state=IDLE, count=0, FIFO pointers=0, starve=0, and all entries invalid.
REQ-024 Output values during and after reset SHALL be: m_read=0, m_write=0, m_byteenable=0, r_waitrequest=1, w_waitrequest=0, idle=1.
REQ-025 Reset mid-transfer SHALL abandon the in-flight command and discard posted writes; there is no replay.

Structure
REQ-026 SHALL place ADDR_W=31, DATA_W=16, and the arbiter state enum in shared package jpeg_pkg.
REQ-027 SHALL implement the FIFO as sub-module jpeg_wr_fifo (push/pop/full/empty/count, plus per-entry address-compare output).

Verification
REQ-028 Single read: r_read, addr 0x100, m_waitrequest low immediately, m_readdata 0xBEEF -> m_read in cycle 1, r_readdata 0xBEEF with r_waitrequest low in cycle 1, IDLE in cycle 2.
REQ-029 Write posting: 4 back-to-back writes with r_read low and m_waitrequest held high -> all 4 accepted, w_waitrequest high on the 5th attempt, idle low.
REQ-030 Starvation: r_read held continuously, one write posted, STARVE_LIMIT=8 -> m_write is issued no later than 10 cycles after the push.
REQ-031 RAW hazard: write 0x1234 to addr 0x40, then read 0x40 in the next cycle -> m_write to 0x40 completes before m_read, and the read returns the memory model's 0x1234.
REQ-032 Reset mid-op: assert rst_n low during WR with m_waitrequest high -> next cycle m_write=0, count=0, idle=1, no further master activity.
REQ-033 Random mix with a scoreboard memory model -> zero data mismatches, and m_read/m_write are never high together.
